// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: AXI-Stream accept, memory write
// addressing, Gray pointer export, read-pointer synchroniser and occupancy flags.
module async_fifo_wr_ctrl #(
    parameter int FIFO_DEPTH   = 32,
    parameter int PTR_WIDTH    = $clog2(FIFO_DEPTH),
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 28
) (
    input  logic                 s_axis_aclk,
    input  logic                 s_axis_areset,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic                 mem_we,
    output logic [PTR_WIDTH-1:0] wr_ptr,
    output logic [PTR_WIDTH:0]   wr_gptr,
    input  logic [PTR_WIDTH:0]   rd_gptr_async,
    output logic                 wr_full,
    output logic                 wr_afull,
    output logic [PTR_WIDTH:0]   wr_level
);

    typedef logic [PTR_WIDTH:0] ptr_t;

    localparam ptr_t AFULL_P = ptr_t'(AFULL_THRESH);

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = '0;
        for (int i = 0; i <= PTR_WIDTH; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    ptr_t wbin_q,  wbin_d;
    ptr_t wgray_q, wgray_d;
    ptr_t level_q, level_d;
    logic full_q,  full_d;
    logic afull_q, afull_d;
    ptr_t rq_sync_q [SYNC_STAGES];
    ptr_t rq_sync_d [SYNC_STAGES];

    logic tready;
    logic accept;
    ptr_t rq;
    ptr_t rbin;
    ptr_t full_cmp;

    // Reset blocks the handshake combinationally so a beat in the reset cycle is dropped.
    assign tready = !full_q && !s_axis_areset;
    assign accept = s_axis_tvalid && tready;
    assign rq     = rq_sync_q[SYNC_STAGES-1];

    always_comb begin
        rq_sync_d[0] = rd_gptr_async;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            rq_sync_d[i] = rq_sync_q[i-1];
        end
    end

    always_comb begin
        wbin_d   = accept ? (wbin_q + ptr_t'(1)) : wbin_q;
        wgray_d  = bin2gray(wbin_d);
        rbin     = gray2bin(rq);
        // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
        full_cmp = {~rq[PTR_WIDTH:PTR_WIDTH-1], rq[PTR_WIDTH-2:0]};
        full_d   = (wgray_d == full_cmp);
        level_d  = wbin_d - rbin;
        afull_d  = (level_d >= AFULL_P);
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            wbin_q    <= '0;
            wgray_q   <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            rq_sync_q <= '{default: '0};
        end else begin
            wbin_q    <= wbin_d;
            wgray_q   <= wgray_d;
            level_q   <= level_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            rq_sync_q <= rq_sync_d;
        end
    end

    assign s_axis_tready = tready;
    assign mem_we        = accept;
    assign wr_ptr        = wbin_q[PTR_WIDTH-1:0];
    assign wr_gptr       = wgray_q;
    assign wr_full       = full_q;
    assign wr_afull      = afull_q;
    assign wr_level      = level_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl with an occupancy-level reference model
// and a data scoreboard over the written memory slots.
module tb_async_fifo_wr_ctrl;

    localparam int DEPTH = 32;
    localparam int PW    = 5;
    localparam int SS    = 2;
    localparam int AF    = 28;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tvalid = 1'b1;
    logic [PW:0]   rd_g = '0;
    logic          s_axis_tready;
    logic          mem_we;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   wr_gptr;
    logic          wr_full;
    logic          wr_afull;
    logic [PW:0]   wr_level;

    always #5 clk = ~clk;

    async_fifo_wr_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .PTR_WIDTH   (PW),
        .SYNC_STAGES (SS),
        .AFULL_THRESH(AF)
    ) dut (
        .s_axis_aclk  (clk),
        .s_axis_areset(rst),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(s_axis_tready),
        .mem_we       (mem_we),
        .wr_ptr       (wr_ptr),
        .wr_gptr      (wr_gptr),
        .rd_gptr_async(rd_g),
        .wr_full      (wr_full),
        .wr_afull     (wr_afull),
        .wr_level     (wr_level)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [PW:0] gray(input int b);
        logic [PW:0] v;
        v = b[PW:0];
        return v ^ (v >> 1);
    endfunction

    // Reference model: write count, delayed view of the read count, level arithmetic.
    int m_wb = 0;
    int m_lvl = 0;
    bit m_full = 0;
    bit m_afull = 0;
    int m_sync[SS];
    bit started = 0;
    int rb_cnt = 0;

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            m_wb = 0; m_lvl = 0; m_full = 0; m_afull = 0;
            for (int i = 0; i < SS; i++) m_sync[i] = 0;
        end else begin
            acc     = tvalid && !m_full;
            m_wb    = (m_wb + (acc ? 1 : 0)) % 64;
            m_lvl   = (m_wb - m_sync[SS-1] + 64) % 64;
            m_full  = (m_lvl == DEPTH);
            m_afull = (m_lvl >= AF);
            for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = rb_cnt % 64;
        end
        started = 1;
    end

    int          sb_mem[DEPTH];
    int          wseq = 0;
    int          rseq = 0;
    logic [PW:0] prev_g = '0;
    bit          have_prev = 0;
    bit          prev_rst = 1;
    bit          wrap_seen = 0;

    always @(negedge clk) begin
        bit trdy_e;
        if (started) begin
            trdy_e = !rst && !m_full;
            chk("tready",   int'(s_axis_tready), int'(trdy_e));
            chk("mem_we",   int'(mem_we),        int'(tvalid && trdy_e));
            chk("wr_ptr",   int'(wr_ptr),        m_wb % DEPTH);
            chk("wr_gptr",  int'(wr_gptr),       int'(gray(m_wb)));
            chk("wr_full",  int'(wr_full),       int'(m_full));
            chk("wr_afull", int'(wr_afull),      int'(m_afull));
            chk("wr_level", int'(wr_level),      m_lvl);
            chk("we_while_full", int'(mem_we && wr_full), 0);
            if (have_prev && !prev_rst && (wr_gptr != prev_g))
                chk("gptr_hamming", $countones(wr_gptr ^ prev_g), 1);
            if (have_prev && !prev_rst && prev_g == 6'b100000 && wr_gptr == 6'b000000)
                wrap_seen = 1;
            if (mem_we) begin
                sb_mem[wr_ptr] = wseq;
                wseq++;
            end
            prev_g    = wr_gptr;
            have_prev = 1;
            prev_rst  = rst;
        end
    end

    // Read pointer advances consume scoreboard entries in order before being exported.
    task automatic drive(input bit r, input bit v, input int rbv);
        @(posedge clk);
        #1;
        while (rb_cnt < rbv) begin
            chk("sb_data", sb_mem[rb_cnt % DEPTH], rseq);
            rseq++;
            rb_cnt++;
        end
        rst    = r;
        tvalid = v;
        rd_g   = gray(rb_cnt);
    endtask

    initial begin
        int start_w;
        int k;
        int nr;
        int avail;

        // Reset held with tvalid high
        repeat (3) @(negedge clk);
        chk("rst_tready", int'(s_axis_tready), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_wr_ptr", int'(wr_ptr), 0);
        chk("rst_gptr",   int'(wr_gptr), 0);
        chk("rst_full",   int'(wr_full), 0);
        chk("rst_afull",  int'(wr_afull), 0);
        chk("rst_level",  int'(wr_level), 0);
        drive(0, 0, 0);
        @(negedge clk);
        chk("release_tready", int'(s_axis_tready), 1);

        // Fill 32 beats with the read pointer parked at 0
        for (int i = 0; i < 32; i++) begin
            drive(0, 1, rb_cnt);
            @(negedge clk);
            chk("fill_wr_ptr", int'(wr_ptr), i);
            chk("fill_mem_we", int'(mem_we), 1);
            if (i == 27) chk("afull_before", int'(wr_afull), 0);
            if (i == 28) chk("afull_after28", int'(wr_afull), 1);
        end
        drive(0, 1, rb_cnt);
        @(negedge clk);
        chk("fill_full",   int'(wr_full), 1);
        chk("fill_tready", int'(s_axis_tready), 0);
        chk("fill_mem_we_blocked", int'(mem_we), 0);
        chk("fill_level",  int'(wr_level), 32);
        chk("fill_gptr",   int'(wr_gptr), 48);

        // Read side releases 5 entries
        drive(0, 0, 5);
        repeat (3) drive(0, 0, rb_cnt);
        @(negedge clk);
        chk("drain_full",   int'(wr_full), 0);
        chk("drain_level",  int'(wr_level), 27);
        chk("drain_afull",  int'(wr_afull), 0);
        chk("drain_tready", int'(s_axis_tready), 1);

        // Interleaved traffic across several pointer wraps
        start_w = wseq;
        k = 0;
        while ((wseq - start_w) < 200 && k < 3000) begin
            nr = rb_cnt;
            if (k % 3 == 0) begin
                avail = wseq - rseq;
                nr = rb_cnt + ((avail < 2) ? avail : 2);
            end
            drive(0, (k % 5 != 3), nr);
            k++;
        end
        chk("wrap_writes_done", int'((wseq - start_w) >= 200), 1);
        chk("wrap_seen", int'(wrap_seen), 1);

        // Empty the FIFO, then build level 31
        drive(0, 0, rb_cnt);
        drive(0, 0, rb_cnt + (wseq - rseq));
        repeat (3) drive(0, 0, rb_cnt);
        @(negedge clk);
        chk("empty_level", int'(wr_level), 0);
        repeat (31) drive(0, 1, rb_cnt);
        drive(0, 0, rb_cnt);
        @(negedge clk);
        chk("l31_level", int'(wr_level), 31);

        // Accept in the same cycle the read advance reaches the synchroniser output
        drive(0, 0, rb_cnt + 1);
        drive(0, 0, rb_cnt);
        drive(0, 1, rb_cnt);
        drive(0, 0, rb_cnt);
        @(negedge clk);
        chk("collide_level", int'(wr_level), 31);
        chk("collide_full",  int'(wr_full), 0);

        // Bring level to 17 and pulse reset with tvalid high
        drive(0, 0, rb_cnt + 14);
        repeat (3) drive(0, 0, rb_cnt);
        @(negedge clk);
        chk("pre_rst_level", int'(wr_level), 17);
        @(posedge clk);
        #1;
        rst = 1; tvalid = 1;
        rb_cnt = 0; rseq = wseq; rd_g = '0;
        @(negedge clk);
        chk("midrst_mem_we", int'(mem_we), 0);
        drive(0, 0, 0);
        @(negedge clk);
        chk("midrst_wr_ptr", int'(wr_ptr), 0);
        chk("midrst_gptr",   int'(wr_gptr), 0);
        chk("midrst_level",  int'(wr_level), 0);
        chk("midrst_full",   int'(wr_full), 0);

        // Traffic after reset still flows
        repeat (5) drive(0, 1, rb_cnt);
        drive(0, 0, rb_cnt);
        @(negedge clk);
        chk("post_rst_level", int'(wr_level), 5);
        drive(0, 0, rb_cnt + 5);
        repeat (3) drive(0, 0, rb_cnt);
        @(negedge clk);
        chk("post_rst_drain", int'(wr_level), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
